// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl
// Programmable, glitch-free even-ratio clock divider controller. The divided
// clock has period 2*(D+1) source cycles. Start, stop and ratio changes are
// sequenced so that a high phase is never shortened, except by reset.
// Ratio updates use a valid/ready handshake. While running, a new ratio is
// held pending and is applied only at a falling edge of clk_out, which is the
// period boundary.
// Optional feature: define CLK_DIV_CTRL_CNT_EN to add the 16-bit edge_cnt
// output. This output counts the rising edges of clk_out.
module clk_div_ctrl #(
    parameter int               CNT_W   = 8,
    parameter logic [CNT_W-1:0] RST_DIV = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [CNT_W-1:0] cfg_div,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    output logic             clk_out,
    output logic             rise_en,
    output logic             busy
`ifdef CLK_DIV_CTRL_CNT_EN
    ,
    output logic [15:0]      edge_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [CNT_W-1:0] div_reg, div_next;
    logic [CNT_W-1:0] pend_div_reg, pend_div_next;
    logic             pend_reg, pend_next;
    logic             clk_out_reg, clk_out_next;
    logic             rise_reg, rise_next;

    logic             accept;
    logic             at_term;
    logic             idle_entry;

    // A new ratio can be taken only when no earlier update is still waiting.
    assign accept  = cfg_valid && !pend_reg;
    // The current half phase ends on the edge where the counter reaches the
    // divide field.
    assign at_term = (cnt_reg == div_reg);

    // Next-state and next-output logic for the controller.
    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        div_next      = div_reg;
        pend_div_next = pend_div_reg;
        pend_next     = pend_reg;
        clk_out_next  = clk_out_reg;
        rise_next     = 1'b0;
        idle_entry    = 1'b0;

        case (state_reg)
            IDLE: begin
                // No clock is running, so a new ratio takes effect at once.
                // This includes an update that arrives on the start edge.
                clk_out_next = 1'b0;
                cnt_next     = '0;
                if (accept) begin
                    div_next = cfg_div;
                end
                if (en) begin
                    state_next = RUN;
                end
            end

            RUN: begin
                if (at_term) begin
                    cnt_next     = '0;
                    clk_out_next = ~clk_out_reg;
                    if (!clk_out_reg) begin
                        rise_next = 1'b1;
                    end else if (pend_reg) begin
                        // Falling edge: the period boundary. Apply the
                        // update that was pending before this edge.
                        div_next  = pend_div_reg;
                        pend_next = 1'b0;
                    end
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
                // An update accepted here waits for the next boundary. If
                // this edge is itself a boundary, the update waits for the
                // boundary after it.
                if (accept) begin
                    pend_div_next = cfg_div;
                    pend_next     = 1'b1;
                end
                if (!en) begin
                    state_next = STOP;
                end
            end

            STOP: begin
                if (!clk_out_reg) begin
                    // The low phase may be cut short. Leave at once.
                    idle_entry = 1'b1;
                end else if (at_term) begin
                    // Finish the high phase, then leave on the falling edge.
                    clk_out_next = 1'b0;
                    idle_entry   = 1'b1;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end

                if (idle_entry) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                    pend_next  = 1'b0;
                    // A value handed over on this very edge is newer than any
                    // pending value. Taking it directly means cfg_ready is
                    // never left low while the controller is idle.
                    if (accept) begin
                        div_next = cfg_div;
                    end else if (pend_reg) begin
                        div_next = pend_div_reg;
                    end
                end else if (accept) begin
                    pend_div_next = cfg_div;
                    pend_next     = 1'b1;
                end
            end

            default: begin
                state_next   = IDLE;
                cnt_next     = '0;
                clk_out_next = 1'b0;
                pend_next    = 1'b0;
            end
        endcase
    end

    // State register: reset returns every output to its idle value at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            div_reg      <= RST_DIV;
            pend_div_reg <= '0;
            pend_reg     <= 1'b0;
            clk_out_reg  <= 1'b0;
            rise_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            div_reg      <= div_next;
            pend_div_reg <= pend_div_next;
            pend_reg     <= pend_next;
            clk_out_reg  <= clk_out_next;
            rise_reg     <= rise_next;
        end
    end

`ifdef CLK_DIV_CTRL_CNT_EN
    logic [15:0] edge_cnt_reg, edge_cnt_next;

    // Count rising edges of clk_out. The count restarts on every start from
    // idle and holds while idle.
    always_comb begin
        edge_cnt_next = edge_cnt_reg;
        if (state_reg == IDLE && en) begin
            edge_cnt_next = '0;
        end else if (rise_next) begin
            edge_cnt_next = edge_cnt_reg + 16'd1;
        end
    end

    // Edge counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_cnt_reg <= '0;
        end else begin
            edge_cnt_reg <= edge_cnt_next;
        end
    end

    assign edge_cnt = edge_cnt_reg;
`endif

    assign cfg_ready = !pend_reg;
    assign clk_out   = clk_out_reg;
    assign rise_en   = rise_reg;
    assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb_clk_div_ctrl
// Testbench for clk_div_ctrl. It has three parts:
// - a table of per-cycle vectors,
// - hand-written multi-cycle sequences for stop, reset and boundary cases,
// - a randomized run checked against a timestamp-based reference model.
module tb_clk_div_ctrl;

    localparam int              CNT_W   = 8;
    localparam logic [CNT_W-1:0] RST_DIV = 8'd0;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             en = 1'b0;
    logic [CNT_W-1:0] cfg_div = '0;
    logic             cfg_valid = 1'b0;
    logic             cfg_ready;
    logic             clk_out;
    logic             rise_en;
    logic             busy;
`ifdef CLK_DIV_CTRL_CNT_EN
    logic [15:0]      edge_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    clk_div_ctrl #(.CNT_W(CNT_W), .RST_DIV(RST_DIV)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .cfg_div   (cfg_div),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .clk_out   (clk_out),
        .rise_en   (rise_en),
        .busy      (busy)
`ifdef CLK_DIV_CTRL_CNT_EN
        ,
        .edge_cnt  (edge_cnt)
`endif
    );

    typedef struct {
        bit         en;
        bit         v;
        logic [7:0] d;
        bit         o;
        bit         r;
        bit         b;
        bit         rdy;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Drive the inputs on the falling edge, then sample 1 time unit after
    // the rising edge.
    task automatic tick(input bit e, input bit v, input logic [7:0] d);
        @(negedge clk);
        en        = e;
        cfg_valid = v;
        cfg_div   = d;
        @(posedge clk);
        #1;
    endtask

    function automatic void addn(input int n, input bit e, input bit v, input logic [7:0] d,
                                 input bit o, input bit r, input bit b, input bit rdy);
        vec_t t;
        t.en = e; t.v = v; t.d = d; t.o = o; t.r = r; t.b = b; t.rdy = rdy;
        for (int i = 0; i < n; i++) vecs.push_back(t);
    endfunction

    // ---------------- Reference model ----------------
    // The model tracks the edge index at which clk_out is next due to toggle.
    // It does not keep a cycle counter.
    bit  m_run, m_stop, m_out, m_rise, m_pend;
    int  m_div, m_pdiv, m_next;
    int  m_ecnt;

    function automatic void model_reset();
        m_run = 0; m_stop = 0; m_out = 0; m_rise = 0; m_pend = 0;
        m_div = int'(RST_DIV); m_pdiv = 0; m_next = 0; m_ecnt = 0;
    endfunction

    function automatic void model_edge(input int n, input bit e, input bit v, input int d);
        bit acc;
        bit was_pend;
        bit to_idle;
        acc      = v && !m_pend;
        was_pend = m_pend;
        to_idle  = 0;
        m_rise   = 0;
        if (!m_run && !m_stop) begin
            if (acc) m_div = d;
            if (e) begin
                m_run  = 1;
                m_next = n + m_div + 1;
                m_ecnt = 0;
            end
        end else if (m_run) begin
            if (n == m_next) begin
                m_out  = !m_out;
                m_rise = m_out;
                if (!m_out && was_pend) begin
                    m_div  = m_pdiv;
                    m_pend = 0;
                end
                m_next = n + m_div + 1;
            end
            if (acc) begin
                m_pdiv = d;
                m_pend = 1;
            end
            if (!e) begin
                m_run  = 0;
                m_stop = 1;
            end
        end else begin
            if (!m_out) to_idle = 1;
            else if (n == m_next) begin
                m_out   = 0;
                to_idle = 1;
            end
            if (to_idle) begin
                m_stop = 0;
                if (acc) m_div = d;
                else if (m_pend) m_div = m_pdiv;
                m_pend = 0;
            end else if (acc) begin
                m_pdiv = d;
                m_pend = 1;
            end
        end
        if (m_rise) m_ecnt = (m_ecnt + 1) % 65536;
    endfunction

    initial begin
        bit found;
        int k;

        // ---------------- Reset ----------------
        #1 rst_n = 1'b0;
        #12;
        check("reset_clk_out", clk_out, 0);
        check("reset_rise_en", rise_en, 0);
        check("reset_busy", busy, 0);
        check("reset_cfg_ready", cfg_ready, 1);
`ifdef CLK_DIV_CTRL_CNT_EN
        check("reset_edge_cnt", edge_cnt, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // ---------------- Table-driven vectors ----------------
        // Divide-by-2 from the reset value of the divide field.
        addn(1, 1, 0, 0,  0, 0, 1, 1);   // start edge E0
        addn(1, 1, 0, 0,  1, 1, 1, 1);   // E0+1 rise
        addn(1, 1, 0, 0,  0, 0, 1, 1);
        addn(1, 1, 0, 0,  1, 1, 1, 1);
        addn(1, 1, 0, 0,  0, 0, 1, 1);
        addn(1, 0, 0, 0,  1, 1, 1, 1);   // en low: rises, then stops
        addn(1, 0, 0, 0,  0, 0, 0, 1);   // high phase completes, idle
        addn(1, 0, 1, 3,  0, 0, 0, 1);   // D=3 taken directly in idle
        // D=3: first rise at E0+4, high 4 cycles, low 4 cycles
        addn(1, 1, 0, 0,  0, 0, 1, 1);   // E0
        addn(3, 1, 0, 0,  0, 0, 1, 1);
        addn(1, 1, 0, 0,  1, 1, 1, 1);   // E0+4
        addn(3, 1, 0, 0,  1, 0, 1, 1);
        addn(1, 1, 0, 0,  0, 0, 1, 1);   // E0+8
        addn(3, 1, 0, 0,  0, 0, 1, 1);
        addn(1, 1, 0, 0,  1, 1, 1, 1);   // E0+12
        // Write D=1 during the high phase. The high phase must still last 4.
        addn(1, 1, 1, 1,  1, 0, 1, 0);
        addn(2, 1, 0, 0,  1, 0, 1, 0);
        addn(1, 1, 0, 0,  0, 0, 1, 1);   // boundary: apply
        addn(1, 1, 0, 0,  0, 0, 1, 1);
        addn(1, 1, 0, 0,  1, 1, 1, 1);   // period 4 from here
        addn(1, 1, 0, 0,  1, 0, 1, 1);
        addn(2, 1, 0, 0,  0, 0, 1, 1);
        addn(1, 1, 0, 0,  1, 1, 1, 1);
        addn(1, 0, 0, 0,  1, 0, 1, 1);   // stop requested while high
        addn(1, 0, 0, 0,  0, 0, 0, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            tick(vecs[i].en, vecs[i].v, vecs[i].d);
            $display("vec %0d en=%0b v=%0b d=%0d -> clk_out=%0b rise_en=%0b busy=%0b cfg_ready=%0b",
                     i, vecs[i].en, vecs[i].v, vecs[i].d, clk_out, rise_en, busy, cfg_ready);
            check($sformatf("vec%0d_clk_out", i), clk_out, vecs[i].o);
            check($sformatf("vec%0d_rise_en", i), rise_en, vecs[i].r);
            check($sformatf("vec%0d_busy", i), busy, vecs[i].b);
            check($sformatf("vec%0d_cfg_ready", i), cfg_ready, vecs[i].rdy);
        end

        // ---------------- Stop with D=2 ----------------
        // Drop en one cycle after a rise.
        tick(1, 1, 2);
        check("stopA_start_busy", busy, 1);
        found = 0;
        k = 0;
        for (int j = 1; j <= 10 && !found; j++) begin
            tick(1, 0, 0);
            if (rise_en) begin
                found = 1;
                k = j;
            end
        end
        check("stopA_rise_found", found, 1);
        check("stopA_rise_delay", k, 3);
        tick(0, 0, 0);
        check("stopA_hold1_out", clk_out, 1);
        check("stopA_hold1_busy", busy, 1);
        tick(0, 0, 0);
        check("stopA_hold2_out", clk_out, 1);
        tick(0, 0, 0);
        check("stopA_end_out", clk_out, 0);
        check("stopA_end_busy", busy, 0);
        $display("seq stop-high D=2: rise after %0d cycles, idle after 3 high cycles", k);

        // Drop en during a low phase: the controller is idle 1 cycle later.
        tick(1, 0, 0);
        check("stopB_start_busy", busy, 1);
        tick(0, 0, 0);
        check("stopB_stop_busy", busy, 1);
        check("stopB_stop_out", clk_out, 0);
        tick(0, 0, 0);
        check("stopB_idle_busy", busy, 0);
        check("stopB_idle_out", clk_out, 0);
        $display("seq stop-low D=2: idle reached");

        // ---------------- Update accepted on a boundary edge ----------------
        // D=1 is set on the start edge. D=0 is written on the first falling
        // edge, so it must take effect one period later.
        tick(1, 1, 1);                    // E0
        tick(1, 0, 0);                    // E0+1
        tick(1, 0, 0);                    // E0+2 rise
        check("bnd_rise1", rise_en, 1);
        tick(1, 0, 0);                    // E0+3
        tick(1, 1, 0);                    // E0+4 fall + accept
        check("bnd_fall1_out", clk_out, 0);
        check("bnd_fall1_ready", cfg_ready, 0);
        tick(1, 0, 0);                    // E0+5
        check("bnd_low_out", clk_out, 0);
        tick(1, 0, 0);                    // E0+6 rise, old ratio kept
        check("bnd_rise2", rise_en, 1);
        tick(1, 0, 0);                    // E0+7
        check("bnd_high2_out", clk_out, 1);
        check("bnd_high2_ready", cfg_ready, 0);
        tick(1, 0, 0);                    // E0+8 fall, apply D=0
        check("bnd_fall2_out", clk_out, 0);
        check("bnd_fall2_ready", cfg_ready, 1);
        tick(0, 0, 0);                    // E0+9 rise at D=0, STOP
        check("bnd_fast_rise", rise_en, 1);
        tick(0, 0, 0);                    // E0+10 fall, idle
        check("bnd_end_busy", busy, 0);
        $display("seq boundary-accept: D=0 applied one period late");

        // ---------------- Asynchronous reset mid high phase ----------------
        tick(0, 1, 5);
        tick(1, 0, 0);
        found = 0;
        for (int j = 1; j <= 20 && !found; j++) begin
            tick(1, 0, 0);
            if (rise_en) begin
                found = 1;
                k = j;
            end
        end
        check("rst_rise_found", found, 1);
        check("rst_rise_delay", k, 6);
        tick(1, 0, 0);
        tick(1, 1, 7);
        check("rst_pre_ready", cfg_ready, 0);
        check("rst_pre_out", clk_out, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_out", clk_out, 0);
        check("rst_async_ready", cfg_ready, 1);
        check("rst_async_busy", busy, 0);
        check("rst_async_rise", rise_en, 0);
        @(negedge clk);
        rst_n = 1'b1;
        en = 1'b0;
        cfg_valid = 1'b0;
        tick(1, 0, 0);
        check("rst_restart_busy", busy, 1);
        check("rst_restart_out", clk_out, 0);
        tick(1, 0, 0);
        check("rst_restart_rise", rise_en, 1);
        tick(0, 0, 0);
        tick(0, 0, 0);
        check("rst_restart_idle", busy, 0);
        $display("seq async-reset D=5: outputs cleared, divide field back to reset value");

        // ---------------- Randomized run against the model ----------------
        @(negedge clk);
        rst_n = 1'b0;
        en = 1'b0;
        cfg_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        begin
            bit         e_r;
            bit         v_r;
            logic [7:0] d_r;
            e_r = 0;
            for (int cyc = 0; cyc < 3000; cyc++) begin
                if ($urandom_range(0, 29) == 0) e_r = !e_r;
                v_r = ($urandom_range(0, 5) == 0);
                d_r = ($urandom_range(0, 49) == 0) ? 8'hFF : 8'($urandom_range(0, 6));
                if (v_r && !m_pend)
                    $display("cfg accepted cyc=%0d div=%0d run=%0b", cyc, d_r, m_run);
                tick(e_r, v_r, d_r);
                model_edge(cyc, e_r, v_r, int'(d_r));
                check($sformatf("rnd%0d_clk_out", cyc), clk_out, m_out);
                check($sformatf("rnd%0d_rise_en", cyc), rise_en, m_rise);
                check($sformatf("rnd%0d_busy", cyc), busy, m_run || m_stop);
                check($sformatf("rnd%0d_cfg_ready", cyc), cfg_ready, !m_pend);
`ifdef CLK_DIV_CTRL_CNT_EN
                check($sformatf("rnd%0d_edge_cnt", cyc), edge_cnt, m_ecnt);
`endif
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/clk_div_ctrl.md
# clk_div_ctrl

Programmable, glitch-free clock divider controller that generates an even-ratio divided clock from `clk` and sequences its start, stop and ratio changes. It extends the fixed divide-by-2 flop into a run-time configurable source for downstream slow-clock domains. Ratio updates arrive over a valid/ready handshake and take effect only at a period boundary, so no high phase is ever shortened.

## Interface
- `CNT_W`, 8: width of the divide field and internal counter.
- `RST_DIV`, 0: divide field value after reset; 0 gives divide-by-2.
- `clk`  in  1  source clock; all state on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `en`  in  1  run request; level-sensitive.
- `cfg_div`  in  CNT_W  divide field D; output period is 2*(D+1) `clk` cycles.
- `cfg_valid`  in  1  `cfg_div` valid.
- `cfg_ready`  out  1  controller can accept a new `cfg_div`.
- `clk_out`  out  1  registered divided clock, 50% duty.
- `rise_en`  out  1  one-cycle pulse, high in the first cycle `clk_out` is high.
- `busy`  out  1  controller is not in IDLE.
- `edge_cnt`  out  16  rising-edge count of `clk_out`; present only with the macro (see Configuration).

## Operation
- Registers: `state` (IDLE, RUN, STOP), `cnt` [CNT_W], `div_r` [CNT_W], `pend_div` [CNT_W], `pend` flag, `clk_out`, `rise_en`.
- Reset: state=IDLE, cnt=0, div_r=RST_DIV, pend=0, clk_out=0, rise_en=0, cfg_ready=1, busy=0, edge_cnt=0.
- `cfg_ready` = !pend. Handshake completes on an edge where cfg_valid && cfg_ready.
- IDLE: clk_out=0. Accepted cfg writes div_r directly. en=1 → RUN with cnt=0; a cfg accepted on that same edge still writes div_r directly.
- RUN/STOP toggle rule: if cnt==div_r then cnt←0, clk_out←~clk_out; else cnt←cnt+1.
- RUN: accepted cfg → pend_div←cfg_div, pend←1. On a falling toggle (clk_out 1→0 = period boundary) with pend=1 set before this edge: div_r←pend_div, pend←0. A cfg accepted on a boundary edge is applied at the next boundary.
- RUN, en=0 → STOP.
- STOP: en ignored. If clk_out=0, go to IDLE on the next edge (low phase may be truncated). If clk_out=1, keep counting; the falling toggle edge also enters IDLE. Pending cfg is applied on the IDLE-entry edge, and pend is cleared.
- `rise_en` ← 1 on the edge where clk_out toggles 0→1, else 0.
- `busy` = (state != IDLE).
- D is unsigned; D=all-ones gives period 2^(CNT_W+1). No illegal values.

## Timing
- en sampled high at edge E0: RUN from E0. First clk_out rise at E0+D+1; rise_en high during the same cycle.
- High and low phases are each exactly D+1 cycles. Steady-state period is 2(D+1).
- New ratio: the first full period at the new ratio starts at the boundary after acceptance. If acceptance coincides with a boundary, it starts one period later.
- cfg_ready drops the cycle after acceptance in RUN and returns the cycle after the apply edge.
- Stop latency: at most D+1 cycles from en sampled low while clk_out is high; 1 cycle if clk_out is low.
- Asynchronous reset mid-period: all outputs return to reset values immediately. clk_out may truncate a high phase only under reset.

## Configuration
- `CLK_DIV_CTRL_CNT_EN` defined: the `edge_cnt` port exists. It increments with wrap on every edge where rise_en is set, is cleared to 0 on IDLE→RUN, and holds in IDLE.
- Not defined: no `edge_cnt` port and no counter logic. All other behaviour is identical.

## Test plan
- Reset defaults with D=0, en=1 at E0 → clk_out toggles at E0+1, E0+2, … (divide-by-2); rise_en high every other cycle.
- D=3 in IDLE, en=1 → period 8, high 4 and low 4 cycles; first rise at E0+4.
- D=3 in RUN, write D=1 mid high phase → cfg_ready=0 until the next falling toggle; the following periods are 4 cycles; no high phase shorter than 4 cycles occurs before the switch.
- D=2, drop en one cycle after a rise → clk_out stays high 3 cycles total, then low with busy=0 on the same edge. Drop en during a low phase → IDLE after 1 cycle.
- Assert rst_n=0 mid high phase with D=5 → clk_out=0, cfg_ready=1, div_r=RST_DIV asynchronously. After release, en=1 restarts from cnt=0.
- With `CLK_DIV_CTRL_CNT_EN`: D=0, run 10 periods → edge_cnt=10. Stop and restart → edge_cnt=0, then counts from 1.
